// File: rtl/sample_stream_reader.sv
// Circular sample store between the 44 kHz capture register and the downstream consumer.
// Optional macro STATUS_COUNTERS_EN adds saturating underrun/overflow event counters.
module sample_stream_reader #(
    parameter int Width = 23,
    parameter int Depth = 4,
    parameter int AddrW = 2
) (
    input  logic             clk44kHz,
    input  logic             reset,
    input  logic             enable,
    input  logic [Width-1:0] datoIn,
    input  logic             listo,
    output logic [Width-1:0] datoOut,
    output logic             valido,
    output logic [AddrW:0]   nivel,
    output logic             vacio,
    output logic             lleno,
`ifdef STATUS_COUNTERS_EN
    output logic [7:0]       cnt_subflujo,
    output logic [7:0]       cnt_desborde,
`endif
    output logic             subflujo,
    output logic             desborde
);

    localparam logic [AddrW:0] FULL_LVL = (AddrW+1)'(Depth);

    logic [Width-1:0] mem_r [Depth];
    logic [AddrW-1:0] wr_ptr_r;
    logic [AddrW-1:0] rd_ptr_r;
    logic [AddrW:0]   nivel_r;
    logic [Width-1:0] dato_r;
    logic             valido_r;
    logic             vacio_r;
    logic             lleno_r;
    logic             subflujo_r;
    logic             desborde_r;

    logic             read_s;
    logic             write_s;
    logic             overflow_s;
    logic             underrun_s;
    logic [AddrW:0]   nivel_nxt_s;
    logic [AddrW:0]   remain_s;
    logic [AddrW-1:0] rd_ptr_nxt_s;
    logic [AddrW-1:0] wr_ptr_nxt_s;
    logic [Width-1:0] head_nxt_s;

    // Handshake decode, occupancy update and next head selection.
    always_comb begin
        read_s       = valido_r & listo;
        write_s      = enable & (~lleno_r | read_s);
        overflow_s   = enable & lleno_r & ~read_s;
        underrun_s   = listo & ~valido_r;
        nivel_nxt_s  = nivel_r;
        remain_s     = nivel_r;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        head_nxt_s   = dato_r;

        case ({write_s, read_s})
            2'b10:   nivel_nxt_s = nivel_r + (AddrW+1)'(1'b1);
            2'b01:   nivel_nxt_s = nivel_r - (AddrW+1)'(1'b1);
            default: nivel_nxt_s = nivel_r;
        endcase

        if (read_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AddrW'(1'b1);
            remain_s     = nivel_r - (AddrW+1)'(1'b1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
            remain_s     = nivel_r;
        end

        if (write_s) begin
            wr_ptr_nxt_s = wr_ptr_r + AddrW'(1'b1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        // An empty store after the pop means the incoming sample becomes the head directly.
        if (nivel_nxt_s == (AddrW+1)'(1'b0)) begin
            head_nxt_s = dato_r;
        end else if (remain_s == (AddrW+1)'(1'b0)) begin
            head_nxt_s = datoIn;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Sample storage; slot under the write pointer is loaded on an accepted write.
    always_ff @(posedge clk44kHz) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_r[i] <= {Width{1'b0}};
            end
        end else if (write_s) begin
            mem_r[wr_ptr_r] <= datoIn;
        end
    end

    // Pointers, occupancy, head register and status flags.
    always_ff @(posedge clk44kHz) begin
        if (reset) begin
            wr_ptr_r   <= {AddrW{1'b0}};
            rd_ptr_r   <= {AddrW{1'b0}};
            nivel_r    <= {(AddrW+1){1'b0}};
            dato_r     <= {Width{1'b0}};
            valido_r   <= 1'b0;
            vacio_r    <= 1'b1;
            lleno_r    <= 1'b0;
            subflujo_r <= 1'b0;
            desborde_r <= 1'b0;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            nivel_r    <= nivel_nxt_s;
            dato_r     <= head_nxt_s;
            valido_r   <= (nivel_nxt_s != (AddrW+1)'(1'b0));
            vacio_r    <= (nivel_nxt_s == (AddrW+1)'(1'b0));
            lleno_r    <= (nivel_nxt_s == FULL_LVL);
            subflujo_r <= underrun_s;
            desborde_r <= overflow_s;
        end
    end

`ifdef STATUS_COUNTERS_EN
    logic [7:0] cnt_sub_r;
    logic [7:0] cnt_des_r;

    // Saturating event counters, stepping on the same edge that raises each pulse.
    always_ff @(posedge clk44kHz) begin
        if (reset) begin
            cnt_sub_r <= 8'd0;
            cnt_des_r <= 8'd0;
        end else begin
            if (underrun_s && (cnt_sub_r != 8'hFF)) begin
                cnt_sub_r <= cnt_sub_r + 8'd1;
            end else begin
                cnt_sub_r <= cnt_sub_r;
            end
            if (overflow_s && (cnt_des_r != 8'hFF)) begin
                cnt_des_r <= cnt_des_r + 8'd1;
            end else begin
                cnt_des_r <= cnt_des_r;
            end
        end
    end

    assign cnt_subflujo = cnt_sub_r;
    assign cnt_desborde = cnt_des_r;
`endif

    assign datoOut  = dato_r;
    assign valido   = valido_r;
    assign nivel    = nivel_r;
    assign vacio    = vacio_r;
    assign lleno    = lleno_r;
    assign subflujo = subflujo_r;
    assign desborde = desborde_r;

endmodule

// File: doc/sample_stream_reader.md
Name: sample_stream_reader

Overview:
- Read-side companion to the sample-capture register in the 44 kHz audio path.
- Captured samples arrive on datoIn with enable as a write strobe and are buffered in a small circular store.
- Samples are presented to the downstream consumer (filter/DAC stage) with a valid/ready handshake.
- Underrun and overflow are flagged and never corrupt stream order.

Parameters:
- Width, 23, sample width in bits.
- Depth, 4, number of sample slots; power of two, at least 2.
- AddrW, 2, pointer width; must equal log2(Depth).

Ports:
- clk44kHz  input  1  sample-rate clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge of clk44kHz.
- enable  input  1  write strobe; datoIn is offered for capture this cycle.
- datoIn  input  Width  sample to store.
- listo  input  1  consumer ready.
- datoOut  output  Width  head sample; registered.
- valido  output  1  datoOut holds an unread sample; registered.
- nivel  output  AddrW+1  stored sample count, 0..Depth; registered.
- vacio  output  1  nivel==0.
- lleno  output  1  nivel==Depth.
- subflujo  output  1  one-cycle underrun pulse.
- desborde  output  1  one-cycle overflow pulse.

Behaviour:
- Reset values: datoOut=0, valido=0, nivel=0, vacio=1, lleno=0, subflujo=0, desborde=0. Read and write pointers are 0.
- Reset mid-operation discards every stored sample. It has priority over any write or read in the same cycle.
- Read occurs when valido and listo are both 1 at a clock edge. The head is popped, and the next sample (if any) appears on datoOut with valido=1 at that same edge.
- Write is accepted when enable=1 and (not lleno, or a read occurs in the same cycle). Data goes to the write pointer, and the pointer advances modulo Depth.
- Latency: a write into an empty block at edge n gives valido=1 and datoOut=datoIn after edge n. The consumer can read at edge n+1.
- Simultaneous write and read: nivel is unchanged. When full, the read frees the slot, the write is accepted, and no desborde is raised.
- Overflow: enable=1 while lleno and no read. The new sample is dropped, stored data is unchanged, and desborde=1 for the cycle after that edge.
- Underrun: listo=1 while valido=0. The consumer is starved, so datoOut holds the last value read (0 after reset) and subflujo=1 for the cycle after that edge. Nothing is popped and nivel is unchanged.
- While valido=0, datoOut keeps its last value and never shows stale storage.
- nivel updates at each edge: +1 on a write without a read, -1 on a read without a write, otherwise unchanged. It never exceeds Depth and never goes below 0.
- Pointers wrap from Depth-1 to 0. Sample order is preserved across wrap.
- vacio and lleno are decoded from the registered nivel.

Optional Feature:
- Macro: STATUS_COUNTERS_EN.
- With it defined, two extra outputs are added: cnt_subflujo[7:0] and cnt_desborde[7:0].
  - Each counts its pulse events and saturates at 255.
  - Both clear on reset.
  - Each increments at the same edge that raises its pulse.
- Without it, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset check: assert reset for 2 cycles, with enable=1 and listo=1 held. All outputs must be at reset values; nivel=0 and vacio=1 on release.
- Basic flow: listo=0; write 0x000011, 0x000022, 0x000033. Expect nivel=3, valido=1, datoOut=0x000011. Then raise listo for 3 cycles: datoOut reads 0x11, 0x22, 0x33 in order, then valido=0 and datoOut stays 0x000033.
- Overflow: with Depth=4 and listo=0, write 1, 2, 3, 4, then 5. Expect lleno=1 and desborde pulses once. Drain yields 1, 2, 3, 4; value 5 never appears.
- Full plus simultaneous read/write: while full, hold enable=1 and listo=1 with 5 then 6. nivel stays 4, no desborde, and output order continues 1, 2, 3, 4, 5, 6.
- Underrun and wrap: perform 10 alternating write/read pairs so the pointers wrap twice, checking order. Then hold listo=1 with no writes for 3 cycles: subflujo pulses each cycle, datoOut is held, and nivel=0.
- Counters (macro defined): force 300 overflow events. Expect cnt_desborde=255 and cnt_subflujo unchanged; reset clears both counters to 0.
